// File: rtl/tdm_demux_pkg.sv
// Shared constants, state encoding and helpers for the TDM 4:1 receive demux.
package tdm_demux_pkg;

    localparam int NUM_SLOTS = 4;
    localparam int SLOT_W    = 2;
    localparam int ERR_CNT_W = 8;

    localparam logic ST_HUNT = 1'b0;
    localparam logic ST_LOCK = 1'b1;

    typedef enum logic {
        HUNT = ST_HUNT,
        LOCK = ST_LOCK
    } state_e;

    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
        return (v == {ERR_CNT_W{1'b1}}) ? v : v + ERR_CNT_W'(1);
    endfunction

endpackage

// File: rtl/tdm_slot_ctr.sv
// Slot index counter for the TDM demux: clear has priority over load-to-1, then increment.
module tdm_slot_ctr
    import tdm_demux_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              inc_i,
    input  logic              load1_i,
    input  logic              clr_i,
    output logic [SLOT_W-1:0] slot_o
);

    logic [SLOT_W-1:0] slot_q;

    // Slot register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            slot_q <= {SLOT_W{1'b0}};
        end else if (clr_i) begin
            slot_q <= {SLOT_W{1'b0}};
        end else if (load1_i) begin
            slot_q <= SLOT_W'(1);
        end else if (inc_i) begin
            slot_q <= slot_q + SLOT_W'(1);
        end else begin
            slot_q <= slot_q;
        end
    end

    assign slot_o = slot_q;

endmodule

// File: rtl/tdm_demux_4to1.sv
// 4-slot TDM receive demux with HUNT/LOCK frame alignment on fsync.
// Optional build macro SYNC_ERR_EN adds the sync_err_o pulse and saturating err_cnt_o.
module tdm_demux_4to1
    import tdm_demux_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             din_valid_i,
    input  logic             fsync_i,
    output logic [WIDTH-1:0] y0_o,
    output logic [WIDTH-1:0] y1_o,
    output logic [WIDTH-1:0] y2_o,
    output logic [WIDTH-1:0] y3_o,
    output logic             y_valid_o,
    output logic             locked_o,
    output logic             s1_o,
    output logic             s0_o
`ifdef SYNC_ERR_EN
    ,
    output logic                 sync_err_o,
    output logic [ERR_CNT_W-1:0] err_cnt_o
`endif
);

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  sh0_q, sh1_q, sh2_q, sh0_d, sh1_d, sh2_d;
    logic [WIDTH-1:0]  y0_q, y1_q, y2_q, y3_q, y0_d, y1_d, y2_d, y3_d;
    logic              yv_q, yv_d;
    logic              slot_inc_s, slot_load_s, slot_clr_s;
    logic [SLOT_W-1:0] slot_s;
`ifdef SYNC_ERR_EN
    logic                 se_q, se_d;
    logic [ERR_CNT_W-1:0] err_q, err_d;
`endif

    tdm_slot_ctr u_slot_ctr (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .inc_i   (slot_inc_s),
        .load1_i (slot_load_s),
        .clr_i   (slot_clr_s),
        .slot_o  (slot_s)
    );

    // Frame alignment FSM, shadow capture and frame commit
    always_comb begin
        state_d     = state_q;
        sh0_d       = sh0_q;
        sh1_d       = sh1_q;
        sh2_d       = sh2_q;
        y0_d        = y0_q;
        y1_d        = y1_q;
        y2_d        = y2_q;
        y3_d        = y3_q;
        yv_d        = 1'b0;
        slot_inc_s  = 1'b0;
        slot_load_s = 1'b0;
        slot_clr_s  = 1'b0;
`ifdef SYNC_ERR_EN
        se_d        = 1'b0;
        err_d       = err_q;
`endif
        if (din_valid_i) begin
            case (state_q)
                HUNT: begin
                    if (fsync_i) begin
                        sh0_d       = din_i;
                        slot_load_s = 1'b1;
                        state_d     = LOCK;
                    end else begin
                        state_d     = HUNT;
                    end
                end
                LOCK: begin
                    if (fsync_i && (slot_s != SLOT_W'(0))) begin
                        // Misaligned sync: restart the frame from this beat
                        sh0_d       = din_i;
                        slot_load_s = 1'b1;
`ifdef SYNC_ERR_EN
                        se_d        = 1'b1;
                        err_d       = sat_inc(err_q);
`endif
                    end else if (!fsync_i && (slot_s == SLOT_W'(0))) begin
                        slot_clr_s  = 1'b1;
                        state_d     = HUNT;
                    end else if (slot_s == SLOT_W'(NUM_SLOTS - 1)) begin
                        y0_d        = sh0_q;
                        y1_d        = sh1_q;
                        y2_d        = sh2_q;
                        y3_d        = din_i;
                        yv_d        = 1'b1;
                        slot_clr_s  = 1'b1;
                    end else begin
                        case (slot_s)
                            2'd0:    sh0_d = din_i;
                            2'd1:    sh1_d = din_i;
                            2'd2:    sh2_d = din_i;
                            default: sh0_d = sh0_q;
                        endcase
                        slot_inc_s  = 1'b1;
                    end
                end
                default: begin
                    state_d     = HUNT;
                    slot_clr_s  = 1'b1;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // State, shadow and output registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= HUNT;
            sh0_q   <= {WIDTH{1'b0}};
            sh1_q   <= {WIDTH{1'b0}};
            sh2_q   <= {WIDTH{1'b0}};
            y0_q    <= {WIDTH{1'b0}};
            y1_q    <= {WIDTH{1'b0}};
            y2_q    <= {WIDTH{1'b0}};
            y3_q    <= {WIDTH{1'b0}};
            yv_q    <= 1'b0;
`ifdef SYNC_ERR_EN
            se_q    <= 1'b0;
            err_q   <= {ERR_CNT_W{1'b0}};
`endif
        end else begin
            state_q <= state_d;
            sh0_q   <= sh0_d;
            sh1_q   <= sh1_d;
            sh2_q   <= sh2_d;
            y0_q    <= y0_d;
            y1_q    <= y1_d;
            y2_q    <= y2_d;
            y3_q    <= y3_d;
            yv_q    <= yv_d;
`ifdef SYNC_ERR_EN
            se_q    <= se_d;
            err_q   <= err_d;
`endif
        end
    end

    assign y0_o      = y0_q;
    assign y1_o      = y1_q;
    assign y2_o      = y2_q;
    assign y3_o      = y3_q;
    assign y_valid_o = yv_q;
    assign locked_o  = (state_q == LOCK);
    assign s1_o      = slot_s[1];
    assign s0_o      = slot_s[0];
`ifdef SYNC_ERR_EN
    assign sync_err_o = se_q;
    assign err_cnt_o  = err_q;
`endif

endmodule

// File: tb/tb_tdm_demux_4to1.sv
// Self-checking bench for tdm_demux_4to1 (WIDTH=4): vector table, corner sequences, random vs. queue model.
module tb_tdm_demux_4to1;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] din;
    logic       din_valid;
    logic       fsync;
    logic [3:0] y0, y1, y2, y3;
    logic       y_valid, locked, s1, s0;
`ifdef SYNC_ERR_EN
    logic       sync_err;
    logic [7:0] err_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    tdm_demux_4to1 #(.WIDTH(4)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .din_i       (din),
        .din_valid_i (din_valid),
        .fsync_i     (fsync),
        .y0_o        (y0),
        .y1_o        (y1),
        .y2_o        (y2),
        .y3_o        (y3),
        .y_valid_o   (y_valid),
        .locked_o    (locked),
        .s1_o        (s1),
        .s0_o        (s0)
`ifdef SYNC_ERR_EN
        ,
        .sync_err_o  (sync_err),
        .err_cnt_o   (err_cnt)
`endif
    );

    // Reference model: collected slots of the current frame in a queue.
    logic [3:0] m_buf[$];
    logic [3:0] m_y[4];
    bit         m_lock;
    bit         m_yv;
    bit         m_se;
    int         m_err;

    task automatic model_reset();
        m_buf.delete();
        for (int i = 0; i < 4; i++) m_y[i] = 4'h0;
        m_lock = 1'b0;
        m_yv   = 1'b0;
        m_se   = 1'b0;
        m_err  = 0;
    endtask

    task automatic model_beat(input logic v, input logic f, input logic [3:0] d);
        m_yv = 1'b0;
        m_se = 1'b0;
        if (v) begin
            if (!m_lock) begin
                if (f) begin
                    m_buf.delete();
                    m_buf.push_back(d);
                    m_lock = 1'b1;
                end
            end else if (f) begin
                if (m_buf.size() != 0) begin
                    m_se  = 1'b1;
                    m_err = (m_err < 255) ? m_err + 1 : 255;
                end
                m_buf.delete();
                m_buf.push_back(d);
            end else if (m_buf.size() == 0) begin
                m_lock = 1'b0;
            end else begin
                m_buf.push_back(d);
                if (m_buf.size() == 4) begin
                    for (int i = 0; i < 4; i++) m_y[i] = m_buf[i];
                    m_yv = 1'b1;
                    m_buf.delete();
                end
            end
        end
    endtask

    task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model(input string tag);
        cmp({tag, ".y"}, {y3, y2, y1, y0}, {m_y[3], m_y[2], m_y[1], m_y[0]});
        cmp({tag, ".y_valid"}, 16'(y_valid), 16'(m_yv));
        cmp({tag, ".locked"}, 16'(locked), 16'(m_lock));
        cmp({tag, ".slot"}, 16'({s1, s0}), 16'(m_buf.size()));
`ifdef SYNC_ERR_EN
        cmp({tag, ".sync_err"}, 16'(sync_err), 16'(m_se));
        cmp({tag, ".err_cnt"}, 16'(err_cnt), 16'(m_err));
`endif
    endtask

    // One clock: present inputs, take the edge, return at the following negedge.
    task automatic step(input logic v, input logic f, input logic [3:0] d);
        din_valid = v;
        fsync     = f;
        din       = d;
        model_beat(v, f, d);
        @(posedge clk);
        @(negedge clk);
        din_valid = 1'b0;
        fsync     = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    typedef struct {
        logic        v;
        logic        f;
        logic [3:0]  d;
        logic [15:0] ey;
        logic        eyv;
        logic        elk;
        logic [1:0]  es;
    } vec_t;

    vec_t tbl[$];

    initial begin
        int yv_cnt;
        logic [3:0] dv;

        din = 4'h0; din_valid = 1'b0; fsync = 1'b0;
        model_reset();
        do_reset();

        cmp("reset.y", {y3, y2, y1, y0}, 16'h0000);
        cmp("reset.locked", 16'(locked), 16'h0000);
        cmp("reset.slot", 16'({s1, s0}), 16'h0000);

        // Aligned frame, idle, misaligned restart, missing sync, relock
        tbl.push_back('{1'b1, 1'b1, 4'hA, 16'h0000, 1'b0, 1'b1, 2'd1});
        tbl.push_back('{1'b1, 1'b0, 4'h5, 16'h0000, 1'b0, 1'b1, 2'd2});
        tbl.push_back('{1'b1, 1'b0, 4'hC, 16'h0000, 1'b0, 1'b1, 2'd3});
        tbl.push_back('{1'b1, 1'b0, 4'h3, 16'h3C5A, 1'b1, 1'b1, 2'd0});
        tbl.push_back('{1'b0, 1'b0, 4'hF, 16'h3C5A, 1'b0, 1'b1, 2'd0});
        tbl.push_back('{1'b1, 1'b1, 4'hA, 16'h3C5A, 1'b0, 1'b1, 2'd1});
        tbl.push_back('{1'b1, 1'b0, 4'h5, 16'h3C5A, 1'b0, 1'b1, 2'd2});
        tbl.push_back('{1'b1, 1'b1, 4'h7, 16'h3C5A, 1'b0, 1'b1, 2'd1});
        tbl.push_back('{1'b1, 1'b0, 4'h1, 16'h3C5A, 1'b0, 1'b1, 2'd2});
        tbl.push_back('{1'b1, 1'b0, 4'h2, 16'h3C5A, 1'b0, 1'b1, 2'd3});
        tbl.push_back('{1'b1, 1'b0, 4'h3, 16'h3217, 1'b1, 1'b1, 2'd0});
        tbl.push_back('{1'b1, 1'b0, 4'h9, 16'h3217, 1'b0, 1'b0, 2'd0});
        tbl.push_back('{1'b1, 1'b0, 4'h4, 16'h3217, 1'b0, 1'b0, 2'd0});
        tbl.push_back('{1'b1, 1'b1, 4'hB, 16'h3217, 1'b0, 1'b1, 2'd1});

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].v, tbl[i].f, tbl[i].d);
            cmp($sformatf("tbl%0d.y", i), {y3, y2, y1, y0}, tbl[i].ey);
            cmp($sformatf("tbl%0d.y_valid", i), 16'(y_valid), 16'(tbl[i].eyv));
            cmp($sformatf("tbl%0d.locked", i), 16'(locked), 16'(tbl[i].elk));
            cmp($sformatf("tbl%0d.slot", i), 16'({s1, s0}), 16'(tbl[i].es));
`ifdef SYNC_ERR_EN
            cmp($sformatf("tbl%0d.sync_err", i), 16'(sync_err), (i == 7) ? 16'h0001 : 16'h0000);
            cmp($sformatf("tbl%0d.err_cnt", i), 16'(err_cnt), (i >= 7) ? 16'h0001 : 16'h0000);
`endif
        end

        // Back-to-back single-bit sweep: y_valid on every 4th beat only
        do_reset();
        for (int d = 0; d < 16; d++) begin
            dv = 4'(d);
            for (int k = 0; k < 4; k++) begin
                step(1'b1, (k == 0), {3'b000, dv[k]});
                cmp($sformatf("sweep%0d.y_valid", d), 16'(y_valid), (k == 3) ? 16'h0001 : 16'h0000);
            end
            cmp($sformatf("sweep%0d.y", d), 16'({y3[0], y2[0], y1[0], y0[0]}), 16'(dv));
        end

        // Gaps of 0..3 idle cycles between the beats of the second frame
        do_reset();
        step(1'b1, 1'b1, 4'h1); step(1'b1, 1'b0, 4'h2);
        step(1'b1, 1'b0, 4'h3); step(1'b1, 1'b0, 4'h4);
        cmp("gap.frame1", {y3, y2, y1, y0}, 16'h4321);
        yv_cnt = 0;
        for (int k = 0; k < 4; k++) begin
            for (int g = 0; g < k; g++) begin
                step(1'b0, 1'b0, 4'hE);
                check_model("gap.idle");
                yv_cnt += int'(y_valid);
            end
            step(1'b1, (k == 0), 4'(9 - k));
            check_model("gap.beat");
            yv_cnt += int'(y_valid);
        end
        cmp("gap.frame2", {y3, y2, y1, y0}, 16'h6789);
        cmp("gap.yv_count", 16'(yv_cnt), 16'h0001);

        // Random traffic, mostly aligned with occasional sync faults
        for (int n = 0; n < 800; n++) begin
            logic v, f;
            v = ($urandom_range(0, 3) != 0);
            f = (m_buf.size() == 0) ^ ($urandom_range(0, 9) == 0);
            step(v, f, 4'($urandom_range(0, 15)));
            check_model("rand");
        end

        // Asynchronous reset mid-frame, asserted between clock edges
        step(1'b1, 1'b1, 4'h6);
        step(1'b1, 1'b0, 4'h7);
        #2 rst = 1'b1;
        #1;
        cmp("arst.y", {y3, y2, y1, y0}, 16'h0000);
        cmp("arst.y_valid", 16'(y_valid), 16'h0000);
        cmp("arst.locked", 16'(locked), 16'h0000);
        cmp("arst.slot", 16'({s1, s0}), 16'h0000);
`ifdef SYNC_ERR_EN
        cmp("arst.err_cnt", 16'(err_cnt), 16'h0000);
`endif
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        step(1'b1, 1'b0, 4'h5);
        check_model("post_rst.nosync");
        step(1'b1, 1'b1, 4'h8); step(1'b1, 1'b0, 4'h9);
        step(1'b1, 1'b0, 4'hA); step(1'b1, 1'b0, 4'hB);
        check_model("post_rst.frame");
        cmp("post_rst.y", {y3, y2, y1, y0}, 16'hBA98);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
